// File: rtl/redmule_outpack_if.sv
// Stream bundle between the cast stage, the output packer and the streamer.
// The master side produces input beats and consumes packed words.
interface redmule_outpack_if #(
    parameter int unsigned DATA_W = 256
);
    logic [DATA_W-1:0]   in_data_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic                in_last_i;
    logic [DATA_W-1:0]   out_data_o;
    logic [DATA_W/8-1:0] out_strb_o;
    logic                out_valid_o;
    logic                out_ready_i;

    modport master (
        output in_data_i, in_valid_i, in_last_i, out_ready_i,
        input  in_ready_o, out_data_o, out_strb_o, out_valid_o
    );

    modport slave (
        input  in_data_i, in_valid_i, in_last_i, out_ready_i,
        output in_ready_o, out_data_o, out_strb_o, out_valid_o
    );
endinterface

// File: rtl/redmule_outpack.sv
// Packs 1, 2 or 4 narrow cast-stage beats into one full-width word with byte strobes,
// buffered through a small FIFO in front of the streamer.
module redmule_outpack #(
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       cast_i,
    input  logic [1:0] ratio_i,
    output logic       busy_o,
    redmule_outpack_if.slave bus
);
    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

    logic [1:0]        k_q;
    logic [1:0]        pe_log_q;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [StrbW-1:0]  mem_strb_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   cnt_q;

    logic [1:0]        new_log, cur_log, last_slot;
    int unsigned       slot_w, fill_bytes;
    logic [DATA_W-1:0] slot_mask, asm_next;
    logic [StrbW-1:0]  strb_next;
    logic              accept, push, pop;

    assign bus.in_ready_o  = (cnt_q < CntW'(FIFO_DEPTH)) && !rst_i && !clear_i;
    assign bus.out_valid_o = (cnt_q != '0);
    assign bus.out_data_o  = bus.out_valid_o ? mem_data_q[rd_ptr_q] : '0;
    assign bus.out_strb_o  = bus.out_valid_o ? mem_strb_q[rd_ptr_q] : '0;
    assign busy_o          = (k_q != 2'd0) || (cnt_q != '0);

    always_comb begin
        new_log   = cast_i ? ((ratio_i == 2'd3) ? 2'd2 : ratio_i) : 2'd0;
        // The pack factor is only sampled at a word boundary.
        cur_log   = (k_q == 2'd0) ? new_log : pe_log_q;
        last_slot = (cur_log == 2'd0) ? 2'd0 : ((cur_log == 2'd1) ? 2'd1 : 2'd3);
        slot_w    = DATA_W >> cur_log;
        slot_mask = {DATA_W{1'b1}} >> (DATA_W - slot_w);
        asm_next  = ((k_q == 2'd0) ? '0 : asm_q)
                  | ((bus.in_data_i & slot_mask) << (32'(k_q) * slot_w));
        accept    = bus.in_valid_i && bus.in_ready_o;
        push      = accept && ((k_q == last_slot) || bus.in_last_i);
        pop       = bus.out_valid_o && bus.out_ready_i;
        fill_bytes = ((32'(k_q) + 32'd1) * StrbW) >> cur_log;
        strb_next = '0;
        for (int unsigned b = 0; b < StrbW; b++) begin
            strb_next[b] = (b < fill_bytes);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            k_q      <= 2'd0;
            pe_log_q <= 2'd0;
            asm_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_strb_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                pe_log_q <= cur_log;
                if (push) begin
                    k_q                  <= 2'd0;
                    mem_data_q[wr_ptr_q] <= asm_next;
                    mem_strb_q[wr_ptr_q] <= strb_next;
                    wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                end else begin
                    k_q   <= k_q + 2'd1;
                    asm_q <= asm_next;
                end
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_redmule_outpack.sv
// Directed bench for the output packer: pass-through, packing, partial words,
// backpressure, soft clear and mid-word ratio changes.
module tb_redmule_outpack;
    localparam int unsigned DataW = 256;

    logic       clk = 1'b0;
    logic       rst, clear, cast;
    logic [1:0] ratio;
    logic       busy;
    int         n_checks = 0;
    int         n_fail   = 0;

    redmule_outpack_if #(.DATA_W(DataW)) bus ();

    redmule_outpack #(.DATA_W(DataW), .FIFO_DEPTH(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .cast_i  (cast),
        .ratio_i (ratio),
        .busy_o  (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DataW-1:0] got,
                            input logic [DataW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [DataW-1:0] d, input logic last);
        bus.in_valid_i = vld;
        bus.in_data_i  = d;
        bus.in_last_i  = last;
    endtask

    logic [DataW-1:0] all_strb, a, b, c, exp;
    logic [DataW-1:0] d [4];

    initial begin
        all_strb = {{(DataW - 32){1'b0}}, 32'hFFFF_FFFF};
        rst = 1'b1; clear = 1'b0; cast = 1'b0; ratio = 2'd0;
        drive(1'b0, '0, 1'b0);
        bus.out_ready_i = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", {255'd0, bus.out_valid_o}, '0);
        check_eq("rst_data", bus.out_data_o, '0);
        check_eq("rst_strb", {224'd0, bus.out_strb_o}, '0);
        check_eq("rst_busy", {255'd0, busy}, '0);
        check_eq("rst_ready", {255'd0, bus.in_ready_o}, '0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_ready", {255'd0, bus.in_ready_o}, 256'd1);

        // Pass-through; ratio must be ignored while cast is low.
        a = {8{32'hA0A0_0001}}; b = {8{32'hB0B0_0002}}; c = {8{32'hC0C0_0003}};
        ratio = 2'd2;
        bus.out_ready_i = 1'b1;
        drive(1'b1, a, 1'b0); tick();
        check_eq("pt_a", bus.out_data_o, a);
        check_eq("pt_a_strb", {224'd0, bus.out_strb_o}, all_strb);
        drive(1'b1, b, 1'b0); tick();
        check_eq("pt_b", bus.out_data_o, b);
        drive(1'b1, c, 1'b0); tick();
        check_eq("pt_c", bus.out_data_o, c);
        check_eq("pt_c_valid", {255'd0, bus.out_valid_o}, 256'd1);
        drive(1'b0, '0, 1'b0); tick();
        check_eq("pt_drained", {255'd0, bus.out_valid_o}, '0);

        // Pack x2 with garbage in the ignored upper half.
        cast = 1'b1; ratio = 2'd1;
        drive(1'b1, {{4{32'hDEAD_BEEF}}, {8{16'h1111}}}, 1'b0); tick();
        check_eq("x2_hold", {255'd0, bus.out_valid_o}, '0);
        check_eq("x2_busy", {255'd0, busy}, 256'd1);
        drive(1'b1, {{4{32'hCAFE_F00D}}, {8{16'h2222}}}, 1'b0); tick();
        check_eq("x2_data", bus.out_data_o, {{8{16'h2222}}, {8{16'h1111}}});
        check_eq("x2_strb", {224'd0, bus.out_strb_o}, all_strb);
        drive(1'b0, '0, 1'b0); tick();

        // Partial x4: three slots then last.
        ratio = 2'd2;
        drive(1'b1, {{6{32'hDEAD_BEEF}}, {4{16'h1111}}}, 1'b0); tick();
        drive(1'b1, {{6{32'hDEAD_BEEF}}, {4{16'h2222}}}, 1'b0); tick();
        check_eq("x4p_hold", {255'd0, bus.out_valid_o}, '0);
        drive(1'b1, {{6{32'hDEAD_BEEF}}, {4{16'h3333}}}, 1'b1); tick();
        check_eq("x4p_data", bus.out_data_o,
                 {64'd0, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}});
        check_eq("x4p_strb", {224'd0, bus.out_strb_o}, 256'h00FF_FFFF);
        drive(1'b0, '0, 1'b0); tick();

        // Ratio 3 behaves as x4.
        ratio = 2'd3;
        for (int i = 0; i < 4; i++) begin
            d[i] = {192'd0, {8{i[3:0] + 4'd4, 4'h0}}};
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, d[i] | {{6{32'hFFFF_FFFF}}, 64'd0}, 1'b0); tick();
            if (i == 2) check_eq("r3_hold", {255'd0, bus.out_valid_o}, '0);
        end
        check_eq("r3_data", bus.out_data_o,
                 {d[3][63:0], d[2][63:0], d[1][63:0], d[0][63:0]});
        check_eq("r3_strb", {224'd0, bus.out_strb_o}, all_strb);
        drive(1'b0, '0, 1'b0); tick();

        // Backpressure with a two-entry FIFO.
        cast = 1'b0; ratio = 2'd0; bus.out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = {8{32'h5000_0000 + i}};
        drive(1'b1, d[0], 1'b0); tick();
        check_eq("bp_rdy1", {255'd0, bus.in_ready_o}, 256'd1);
        drive(1'b1, d[1], 1'b0); tick();
        check_eq("bp_full", {255'd0, bus.in_ready_o}, '0);
        check_eq("bp_head0", bus.out_data_o, d[0]);
        drive(1'b1, d[2], 1'b0); tick();
        check_eq("bp_stable", bus.out_data_o, d[0]);
        check_eq("bp_stable_rdy", {255'd0, bus.in_ready_o}, '0);
        bus.out_ready_i = 1'b1; tick();
        check_eq("bp_d1", bus.out_data_o, d[1]);
        check_eq("bp_reopen", {255'd0, bus.in_ready_o}, 256'd1);
        tick();
        check_eq("bp_d2", bus.out_data_o, d[2]);
        drive(1'b1, d[3], 1'b0); tick();
        check_eq("bp_d3", bus.out_data_o, d[3]);
        drive(1'b0, '0, 1'b0); tick();
        check_eq("bp_empty", {255'd0, bus.out_valid_o}, '0);

        // Mid-word clear discards the partial word.
        cast = 1'b1; ratio = 2'd1;
        drive(1'b1, {128'd0, {4{32'h9999_9999}}}, 1'b0); tick();
        check_eq("clr_busy_pre", {255'd0, busy}, 256'd1);
        drive(1'b0, '0, 1'b0); clear = 1'b1; #1;
        check_eq("clr_ready_low", {255'd0, bus.in_ready_o}, '0);
        tick();
        clear = 1'b0; #1;
        check_eq("clr_busy", {255'd0, busy}, '0);
        check_eq("clr_valid", {255'd0, bus.out_valid_o}, '0);
        check_eq("clr_ready", {255'd0, bus.in_ready_o}, 256'd1);
        drive(1'b1, {128'd0, {4{32'h7777_0001}}}, 1'b0); tick();
        drive(1'b1, {128'd0, {4{32'h7777_0002}}}, 1'b0); tick();
        check_eq("clr_fresh", bus.out_data_o, {{4{32'h7777_0002}}, {4{32'h7777_0001}}});
        drive(1'b0, '0, 1'b0); tick();

        // Ratio change mid-word takes effect only on the next word.
        ratio = 2'd1;
        drive(1'b1, {128'd0, {8{16'hAAAA}}}, 1'b0); tick();
        ratio = 2'd0;
        drive(1'b1, {{8{16'hEEEE}}, {8{16'hBBBB}}}, 1'b0); tick();
        check_eq("rc_word", bus.out_data_o, {{8{16'hBBBB}}, {8{16'hAAAA}}});
        exp = {{8{16'h1234}}, {8{16'h5678}}};
        drive(1'b1, exp, 1'b0); tick();
        check_eq("rc_p1", bus.out_data_o, exp);
        check_eq("rc_p1_strb", {224'd0, bus.out_strb_o}, all_strb);
        drive(1'b0, '0, 1'b0); tick();
        check_eq("rc_idle", {255'd0, busy}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/redmule_outpack.md
REDMULE_OUTPACK -- requirements
Module: redmule_outpack

Interface
REQ-001 Parameter DATA_W, default 256: width in bits of input and output data words; SHALL be a multiple of 32.
REQ-002 Parameter FIFO_DEPTH, default 2: number of output FIFO entries; SHALL be at least 2.
REQ-003 Port clk_i, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i, input, 1: synchronous, active-high reset.
REQ-005 Port clear_i, input, 1: synchronous, active-high soft clear.
REQ-006 Port cast_i, input, 1: packing enable; when 0, beats pass through unpacked.
REQ-007 Port ratio_i, input, 2: log2 of the pack factor P (0 gives P=1, 1 gives P=2, 2 gives P=4); value 3 SHALL be treated as 2.
REQ-008 Port in_data_i, input, DATA_W: cast-stage output beat; valid narrow payload sits in bits [DATA_W/P-1:0].
REQ-009 Port in_valid_i / in_ready_o, input / output, 1 each: input handshake.
REQ-010 Port in_last_i, input, 1: marks the final beat of a tile; forces emission of a partial word.
REQ-011 Port out_data_o, output, DATA_W: packed word to the streamer.
REQ-012 Port out_strb_o, output, DATA_W/8: byte strobes of out_data_o.
REQ-013 Port out_valid_o / out_ready_i, output / input, 1 each: output handshake.
REQ-014 Port busy_o, output, 1: high while any beat is held in the assembly register or the FIFO.

Function
REQ-015 A transfer occurs on an edge where valid and ready are both high; out_valid_o SHALL NOT depend combinationally on out_ready_i.
REQ-016 Effective factor Pe: 1 if cast_i=0, otherwise P; Pe SHALL be latched on the first beat of each word and held until that word is emitted.
REQ-017 Slot counter k (0..Pe-1): an accepted beat writes in_data_i[DATA_W/Pe-1:0] to assembly bits [k*DATA_W/Pe +: DATA_W/Pe]; k then increments.
REQ-018 A word completes when k reaches Pe-1 on an accepted beat, or when in_last_i=1 on an accepted beat; on completion the word is pushed to the FIFO and k returns to 0.
REQ-019 Strobes: a full word SHALL carry all ones; a partial word with n filled slots SHALL set strobes only for bytes [0 .. n*DATA_W/(8*Pe)-1].
REQ-020 Assembly bits not written in a partial word SHALL be zero.
REQ-021 in_ready_o SHALL be 1 iff the FIFO occupancy is below FIFO_DEPTH; it SHALL be 0 while rst_i or clear_i is high.
REQ-022 Latency: a completed word SHALL appear at the FIFO head, with out_valid_o=1, on the cycle after the completing beat is accepted (pass-through latency is 1 cycle).
REQ-023 FIFO order SHALL be first-in first-out; a push and a pop on the same edge SHALL leave occupancy unchanged.
REQ-024 When the FIFO is full, no input beat is accepted; out_data_o and out_strb_o SHALL hold steady while out_valid_o=1 and out_ready_i=0.
REQ-025 Changes to cast_i or ratio_i while k is not 0 SHALL be ignored until the current word completes.
REQ-026 in_data_i bits above DATA_W/Pe SHALL be ignored.

Reset
REQ-027 When rst_i=1: out_valid_o=0, out_data_o=0, out_strb_o=0, busy_o=0, in_ready_o=0, k=0, FIFO empty, Pe=1.
REQ-028 clear_i=1 SHALL have the same effect as rst_i, with priority over any handshake on the same edge, and SHALL discard partially assembled and queued words.
REQ-029 After rst_i or clear_i deasserts, in_ready_o SHALL be 1 on the next cycle.

Verification
REQ-030 Pass-through: cast_i=0, 3 beats A,B,C, out_ready_i=1 -> outputs A,B,C on consecutive cycles, each 1 cycle after input, strb all ones.
REQ-031 Pack x2: cast_i=1, ratio_i=1, beats with low halves 0x11.., 0x22.. -> one word {0x22..,0x11..}, strb all ones, 1 cycle after the second beat.
REQ-032 Partial x4: ratio_i=2, 3 beats, in_last_i on the 3rd -> strb low 3/4 of bytes set, top quarter of data = 0.
REQ-033 Backpressure: out_ready_i=0, ratio_i=0, 4 beats offered -> in_ready_o drops after FIFO_DEPTH accepts; the held head stays stable; releasing out_ready_i drains all 4 beats in order.
REQ-034 Mid-word clear: ratio_i=1, one beat accepted, clear_i pulsed -> no output, busy_o=0; the next two beats form one fresh word.
REQ-035 Mid-word ratio change: ratio_i changes 1->0 after the first beat -> the second beat still fills the upper half; the following word is packed with P=1.
